// File: rtl/mul_cell_seq.sv
// mul_cell_seq: 32x32 -> 64-bit multiply sequenced over one external pipelined 16x16 multiplier cell.
// Four half-word partials are issued, tagged through a latency-matched pipe and summed into a 64-bit accumulator.
module mul_cell_seq #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic        in_src1_signed,
  input  logic        in_src2_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        busy,
  output logic [15:0] mul_dataa,
  output logic [15:0] mul_datab,
  output logic        mul_signa,
  output logic        mul_signb,
  output logic        mul_en,
  input  logic [31:0] mul_result
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [1:0] DRAIN_LAST = 2'(MUL_LATENCY - 1);

  state_t      state, state_next;
  logic [1:0]  idx, drain_cnt;
  logic [31:0] src1_q, src2_q;
  logic        src1_signed_q, src2_signed_q;
  logic [63:0] acc;
  logic        started;
  logic [MUL_LATENCY-1:0] tag_vld;
  logic [1:0]  tag_idx [MUL_LATENCY];
  logic        accept, emerge, emerge_signed;
  logic [1:0]  emerge_idx;
  logic [63:0] partial_ext, partial_shifted;

  assign accept     = in_valid & in_ready;
  assign busy       = (state != IDLE);
  assign out_result = acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
    end
  end

  // idx bit 1 selects the high half of A, bit 0 the high half of B.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mul_en     = 1'b0;
    mul_dataa  = '0;
    mul_datab  = '0;
    mul_signa  = 1'b0;
    mul_signb  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = started;
        if (in_valid && started) state_next = ISSUE;
      end
      ISSUE: begin
        mul_en    = 1'b1;
        mul_dataa = idx[1] ? src1_q[31:16] : src1_q[15:0];
        mul_datab = idx[0] ? src2_q[31:16] : src2_q[15:0];
        mul_signa = idx[1] & src1_signed_q;
        mul_signb = idx[0] & src2_signed_q;
        if (idx == 2'd3) state_next = DRAIN;
      end
      DRAIN: begin
        mul_en = (drain_cnt != DRAIN_LAST);
        if (drain_cnt == DRAIN_LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx           <= '0;
      drain_cnt     <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      src1_signed_q <= 1'b0;
      src2_signed_q <= 1'b0;
    end else begin
      if (accept) begin
        idx           <= '0;
        src1_q        <= in_src1;
        src2_q        <= in_src2;
        src1_signed_q <= in_src1_signed;
        src2_signed_q <= in_src2_signed;
      end else if (state == ISSUE) begin
        idx <= idx + 2'd1;
      end
      if (state == ISSUE) drain_cnt <= '0;
      else if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
    end
  end

  // Tags advance in lockstep with the multiplier's enabled pipeline stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) tag_idx[i] <= '0;
    end else if (accept) begin
      tag_vld <= '0;
    end else if (mul_en) begin
      tag_vld[0] <= (state == ISSUE);
      tag_idx[0] <= idx;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  // The last partial sits at the pipe output after DRAIN; gating on state stops a double add in DONE.
  always_comb begin
    emerge_idx    = tag_idx[MUL_LATENCY-1];
    emerge        = tag_vld[MUL_LATENCY-1] && ((state == ISSUE) || (state == DRAIN));
    emerge_signed = (emerge_idx[1] & src1_signed_q) | (emerge_idx[0] & src2_signed_q);
    partial_ext   = emerge_signed ? {{32{mul_result[31]}}, mul_result} : {32'b0, mul_result};
    case (emerge_idx)
      2'd0:    partial_shifted = partial_ext;
      2'd3:    partial_shifted = partial_ext << 32;
      default: partial_shifted = partial_ext << 16;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    acc <= '0;
    else if (accept) acc <= '0;
    else if (emerge) acc <= acc + partial_shifted;
  end

endmodule

// File: tb/tb_mul_cell_seq.sv
// tb_mul_cell_seq: scoreboard bench for mul_cell_seq at MUL_LATENCY=1 (directed + random) and 3 (random),
// each driving a behavioural ena-gated 16x16 multiplier.
module tb_mul_cell_seq;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        a_in_valid, a_in_ready, a_s1, a_s2, a_out_valid, a_out_ready, a_busy;
  logic [31:0] a_src1, a_src2, a_mres;
  logic [63:0] a_out_result;
  logic [15:0] a_dataa, a_datab;
  logic        a_signa, a_signb, a_en;

  logic        b_in_valid, b_in_ready, b_s1, b_s2, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_src1, b_src2, b_mres;
  logic [63:0] b_out_result;
  logic [15:0] b_dataa, b_datab;
  logic        b_signa, b_signb, b_en;

  logic [63:0] exp_a [$];
  logic [63:0] exp_b [$];

  mul_cell_seq #(.MUL_LATENCY(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_src1(a_src1), .in_src2(a_src2), .in_src1_signed(a_s1), .in_src2_signed(a_s2),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result), .busy(a_busy),
    .mul_dataa(a_dataa), .mul_datab(a_datab), .mul_signa(a_signa), .mul_signb(a_signb),
    .mul_en(a_en), .mul_result(a_mres)
  );

  mul_cell_seq #(.MUL_LATENCY(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_src1(b_src1), .in_src2(b_src2), .in_src1_signed(b_s1), .in_src2_signed(b_s2),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result), .busy(b_busy),
    .mul_dataa(b_dataa), .mul_datab(b_datab), .mul_signa(b_signa), .mul_signb(b_signb),
    .mul_en(b_en), .mul_result(b_mres)
  );

  function automatic logic [31:0] cell_mul(input logic [15:0] x, input logic [15:0] y,
                                           input logic sx, input logic sy);
    logic signed [16:0] ex, ey;
    logic signed [33:0] p;
    ex = {sx & x[15], x};
    ey = {sy & y[15], y};
    p  = ex * ey;
    return p[31:0];
  endfunction

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic sx, input logic sy);
    logic signed [32:0] ex, ey;
    logic signed [65:0] p;
    ex = {sx & x[31], x};
    ey = {sy & y[31], y};
    p  = ex * ey;
    return p[63:0];
  endfunction

  // Behavioural external multipliers: ena-gated pipelines of depth 1 and 3.
  logic [31:0] a_mpipe;
  logic [31:0] b_mpipe [3];
  always @(posedge clk) if (a_en) a_mpipe <= cell_mul(a_dataa, a_datab, a_signa, a_signb);
  always @(posedge clk) begin
    if (b_en) begin
      b_mpipe[0] <= cell_mul(b_dataa, b_datab, b_signa, b_signb);
      b_mpipe[1] <= b_mpipe[0];
      b_mpipe[2] <= b_mpipe[1];
    end
  end
  assign a_mres = a_mpipe;
  assign b_mres = b_mpipe[2];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, act, expv);
    end
  endtask

  // Monitors pop the scoreboard on every completed output handshake.
  always @(negedge clk) begin
    if (reset_n && a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) check_output("a_unexpected_result", 64'd1, 64'd0);
      else check_output("a_result", a_out_result, exp_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset_n && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) check_output("b_unexpected_result", 64'd1, 64'd0);
      else check_output("b_result", b_out_result, exp_b.pop_front());
    end
  end

  task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] y, input logic sx,
                                input logic sy, input logic [63:0] expv,
                                output int lat, output int en_cnt, output int waits);
    waits = 0;
    while (!a_in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check_output("a_ready_wait", 64'(a_in_ready), 64'd1);
    a_in_valid = 1'b1;
    a_src1 = x; a_src2 = y; a_s1 = sx; a_s2 = sy;
    @(posedge clk);
    exp_a.push_back(expv);
    #1;
    a_in_valid = 1'b0;
    a_src1 = $urandom; a_src2 = $urandom; a_s1 = 1'($urandom); a_s2 = 1'($urandom);
    lat = 0;
    en_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (a_en) en_cnt++;
    end while (!a_out_valid && lat < 40);
  endtask

  task automatic run_a(input logic [31:0] x, input logic [31:0] y, input logic sx, input logic sy,
                       input logic [63:0] expv);
    int lat, en_cnt, waits;
    apply_stimulus(x, y, sx, sy, expv, lat, en_cnt, waits);
    check_output("a_latency", 64'(lat), 64'd6);
    check_output("a_mul_en_cycles", 64'(en_cnt), 64'd4);
  endtask

  task automatic run_random_b(input int n);
    logic [31:0] x, y;
    logic sx, sy;
    int lat, en_cnt, guard;
    for (int v = 0; v < n; v++) begin
      x = $urandom; y = $urandom;
      sx = 1'($urandom); sy = 1'($urandom);
      if ($urandom_range(0, 7) == 0) x = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) y = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
      guard = 0;
      @(negedge clk);
      while (!b_in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (!b_in_ready) check_output("b_ready_timeout", 64'd0, 64'd1);
      b_in_valid = 1'b1;
      b_src1 = x; b_src2 = y; b_s1 = sx; b_s2 = sy;
      @(posedge clk);
      exp_b.push_back(ref_mul(x, y, sx, sy));
      #1;
      b_in_valid = 1'($urandom);
      b_src1 = $urandom; b_src2 = $urandom; b_s1 = 1'($urandom); b_s2 = 1'($urandom);
      lat = 0;
      en_cnt = 0;
      do begin
        @(negedge clk);
        lat++;
        if (b_en) en_cnt++;
      end while (!b_out_valid && lat < 60);
      b_in_valid = 1'b0;
      check_output("b_latency", 64'(lat), 64'd8);
      check_output("b_mul_en_cycles", 64'(en_cnt), 64'd6);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, en_cnt, waits, guard;
    reset_n = 1'b0;
    a_in_valid = 1'b0; a_src1 = '0; a_src2 = '0; a_s1 = 1'b0; a_s2 = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_src1 = '0; b_src2 = '0; b_s1 = 1'b0; b_s2 = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_in_ready", 64'(a_in_ready), 64'd0);
    check_output("rst_flags", {60'd0, a_out_valid, a_busy, a_en, b_in_ready}, 64'd0);
    check_output("rst_mul_bus", {30'd0, a_dataa, a_datab, a_signa, a_signb}, 64'd0);
    check_output("rst_out_result", a_out_result, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("post_rst_in_ready", 64'(a_in_ready), 64'd1);

    run_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001);
    run_a(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
    run_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001);
    run_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0001);

    // Backpressure: result must hold, multiplier idle, new requests refused.
    @(posedge clk);
    #1 a_out_ready = 1'b0;
    apply_stimulus(32'h0001_0003, 32'hFFFF_FFFE, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFD_FFFA, lat, en_cnt, waits);
    check_output("bp_latency", 64'(lat), 64'd6);
    a_in_valid = 1'b1; a_src1 = 32'h1234_0000; a_src2 = 32'h0000_4321;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("bp_result_hold", a_out_result, 64'hFFFF_FFFF_FFFD_FFFA);
      check_output("bp_flags", {61'd0, a_out_valid, a_en, a_in_ready}, 64'b100);
    end
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    a_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("bp_release_idle", {62'd0, a_in_ready, a_busy}, 64'b10);
    apply_stimulus(32'h0000_0007, 32'h0000_0009, 1'b0, 1'b0, 64'd63, lat, en_cnt, waits);
    check_output("bp_back_to_back", 64'(waits), 64'd0);

    // Reset during issue cycle C3, checking issue order on the way.
    while (!a_in_ready) @(negedge clk);
    a_in_valid = 1'b1; a_src1 = 32'h1111_2222; a_src2 = 32'h3333_4444; a_s1 = 1'b1; a_s2 = 1'b1;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    @(negedge clk);
    check_output("issue0_bus", {30'd0, a_dataa, a_datab, a_signa, a_signb}, {30'd0, 16'h2222, 16'h4444, 2'b00});
    @(negedge clk);
    check_output("issue1_bus", {30'd0, a_dataa, a_datab, a_signa, a_signb}, {30'd0, 16'h2222, 16'h3333, 2'b01});
    @(negedge clk);
    check_output("issue2_bus", {30'd0, a_dataa, a_datab, a_signa, a_signb}, {30'd0, 16'h1111, 16'h4444, 2'b10});
    reset_n = 1'b0;
    #1;
    check_output("midrst_flags", {60'd0, a_in_ready, a_out_valid, a_busy, a_en}, 64'd0);
    check_output("midrst_mul_bus", {30'd0, a_dataa, a_datab, a_signa, a_signb}, 64'd0);
    check_output("midrst_out_result", a_out_result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_a(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 64'h0B00_EA4E_242D_2080);

    for (int v = 0; v < 100; v++) begin
      logic [31:0] x, y;
      logic sx, sy;
      x = $urandom; y = $urandom; sx = 1'($urandom); sy = 1'($urandom);
      run_a(x, y, sx, sy, ref_mul(x, y, sx, sy));
    end

    fork
      run_random_b(1000);
      forever begin
        @(posedge clk);
        #1 b_out_ready = ($urandom_range(0, 3) != 0);
      end
    join_any
    disable fork;
    @(posedge clk);
    #1 b_out_ready = 1'b1;

    guard = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_output("scoreboard_drained", 64'(exp_a.size() + exp_b.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
